// File: rtl/mac_vec_datapath.sv
// rtl/mac_vec_datapath.sv - multi-lane signed MAC with rescale and saturation (optional MAC_VEC_RELU_EN clamps negative results to zero)
module mac_vec_datapath #(
    parameter int WIDTH = 12,
    parameter int LANES = 2,
    parameter int K     = 4,
    parameter int FRAC  = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LANES*WIDTH-1:0]   in_m,
    input  logic [LANES*WIDTH-1:0]   in_v,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANES*WIDTH-1:0]   out_data,
    output logic [LANES-1:0]         out_sat
);

    localparam int ACC_W = 2*WIDTH + $clog2(K) + 1;
    localparam int CNT_W = (K > 1) ? $clog2(K) : 1;

    // Saturation bounds expressed at accumulator width for direct comparison.
    localparam logic signed [ACC_W-1:0] MAX_V = {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MIN_V = {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    typedef enum logic {ACCUM, DRAIN} state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q;
    logic signed [ACC_W-1:0] acc_q [LANES];
    logic signed [ACC_W-1:0] sum   [LANES];
    logic [LANES*WIDTH-1:0]  res_d;
    logic [LANES-1:0]        sat_d;
    logic                    accept;
    logic                    last;

    // A beat counts only in ACCUM with clear low; clear drops the beat.
    assign accept = in_valid && (state_q == ACCUM) && !clear;
    assign last   = (cnt_q == CNT_W'(K-1));

    // Per-lane product, running sum, rescale and saturation.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic signed [2*WIDTH-1:0] m_e, v_e, prod;
        logic signed [ACC_W-1:0]   shr;
        logic [WIDTH-1:0]          res_l;
        logic                      sat_l;

        assign m_e    = {{WIDTH{in_m[i*WIDTH+WIDTH-1]}}, in_m[i*WIDTH +: WIDTH]};
        assign v_e    = {{WIDTH{in_v[i*WIDTH+WIDTH-1]}}, in_v[i*WIDTH +: WIDTH]};
        // Operands sign-extended to 2*WIDTH, so the truncated product is exact.
        assign prod   = m_e * v_e;
        assign sum[i] = acc_q[i] + {{(ACC_W-2*WIDTH){prod[2*WIDTH-1]}}, prod};

        // Floor-rescale the final sum, then clamp into WIDTH bits.
        always_comb begin
            shr   = sum[i] >>> FRAC;
            res_l = shr[WIDTH-1:0];
            sat_l = 1'b0;
            if (shr > MAX_V) begin
                res_l = MAX_V[WIDTH-1:0];
                sat_l = 1'b1;
            end else if (shr < MIN_V) begin
                res_l = MIN_V[WIDTH-1:0];
                sat_l = 1'b1;
            end
`ifdef MAC_VEC_RELU_EN
            if (shr < 0) begin
                res_l = '0;
                sat_l = 1'b0;
            end
`endif
        end

        assign res_d[i*WIDTH +: WIDTH] = res_l;
        assign sat_d[i]                = sat_l;
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ACCUM;
        else        state_q <= state_d;
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        case (state_q)
            ACCUM: begin
                in_ready = 1'b1;
                if (accept && last) state_d = DRAIN;
            end
            DRAIN: begin
                if (out_ready) state_d = ACCUM;
            end
            default: state_d = ACCUM;
        endcase
    end

    // Accumulators, beat counter and the registered output beat.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < LANES; i++) acc_q[i] <= '0;
            cnt_q     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= '0;
        end else if (state_q == ACCUM) begin
            if (clear) begin
                for (int i = 0; i < LANES; i++) acc_q[i] <= '0;
                cnt_q <= '0;
            end else if (in_valid) begin
                if (last) begin
                    for (int i = 0; i < LANES; i++) acc_q[i] <= '0;
                    cnt_q     <= '0;
                    out_data  <= res_d;
                    out_sat   <= sat_d;
                    out_valid <= 1'b1;
                end else begin
                    for (int i = 0; i < LANES; i++) acc_q[i] <= sum[i];
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mac_vec_datapath.sv
// tb/tb_mac_vec_datapath.sv - directed self-checking bench for mac_vec_datapath (honours MAC_VEC_RELU_EN)
module tb_mac_vec_datapath;

    logic        clk = 1'b0;
    logic        reset;
    logic        clear;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] in_m, in_v;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] out_data;
    logic [1:0]  out_sat;

    logic        r_clear;
    logic        r_in_valid;
    logic        r_in_ready;
    logic [23:0] r_in_m, r_in_v;
    logic        r_out_valid;
    logic        r_out_ready;
    logic [23:0] r_out_data;
    logic [1:0]  r_out_sat;

    int checks = 0;
    int errors = 0;
    logic [23:0] exp_d;
    logic [1:0]  exp_s;

    always #5 clk = ~clk;

    mac_vec_datapath #(.WIDTH(12), .LANES(2), .K(4), .FRAC(0)) u_dut (
        .clk(clk), .reset(reset), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_m(in_m), .in_v(in_v),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat)
    );

    mac_vec_datapath #(.WIDTH(12), .LANES(2), .K(1), .FRAC(4)) u_rs (
        .clk(clk), .reset(reset), .clear(r_clear),
        .in_valid(r_in_valid), .in_ready(r_in_ready), .in_m(r_in_m), .in_v(r_in_v),
        .out_valid(r_out_valid), .out_ready(r_out_ready), .out_data(r_out_data), .out_sat(r_out_sat)
    );

    task automatic beat(input int m0, input int v0, input int m1, input int v1);
        in_valid = 1'b1;
        in_m     = {12'(m1), 12'(m0)};
        in_v     = {12'(v1), 12'(v0)};
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", in_ready); end
        checks++; if (out_data !== 24'h0) begin errors++; $display("FAIL reset_data: got %h expected 000000", out_data); end
        checks++; if (out_sat !== 2'b00) begin errors++; $display("FAIL reset_sat: got %b expected 00", out_sat); end
        checks++; if (r_out_valid !== 1'b0) begin errors++; $display("FAIL reset_rs_valid: got %b expected 0", r_out_valid); end
    endtask

    task automatic test_basic;
        out_ready = 1'b1;
        beat(1, 5, -1, 5);
        beat(2, 6, -2, 6);
        beat(3, 7, -3, 7);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid: got %b expected 0", out_valid); end
        beat(4, 8, -4, 8);
`ifdef MAC_VEC_RELU_EN
        exp_d = {12'(0), 12'(70)};
`else
        exp_d = {12'(-70), 12'(70)};
`endif
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b expected 1", out_valid); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL basic_drain_ready: got %b expected 0", in_ready); end
        checks++; if (out_data !== exp_d) begin errors++; $display("FAIL basic_data: got %h expected %h", out_data, exp_d); end
        checks++; if (out_sat !== 2'b00) begin errors++; $display("FAIL basic_sat: got %b expected 00", out_sat); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_drop: got %b expected 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_ready_back: got %b expected 1", in_ready); end
    endtask

    task automatic test_saturation;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) beat(2047, 2047, 2047, -2048);
`ifdef MAC_VEC_RELU_EN
        exp_d = {12'(0), 12'(2047)};
        exp_s = 2'b01;
`else
        exp_d = {12'(-2048), 12'(2047)};
        exp_s = 2'b11;
`endif
        checks++; if (out_data !== exp_d) begin errors++; $display("FAIL sat_data: got %h expected %h", out_data, exp_d); end
        checks++; if (out_sat !== exp_s) begin errors++; $display("FAIL sat_flags: got %b expected %b", out_sat, exp_s); end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) beat(1, 1, 2, 3);
        exp_d = {12'(24), 12'(4)};
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid: got %b expected 1", out_valid); end
        in_valid = 1'b1;
        in_m     = {12'(100), 12'(100)};
        in_v     = {12'(100), 12'(100)};
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid: cycle %0d got %b expected 1", c, out_valid); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_hold_ready: cycle %0d got %b expected 0", c, in_ready); end
            checks++; if (out_data !== exp_d) begin errors++; $display("FAIL bp_hold_data: cycle %0d got %h expected %h", c, out_data, exp_d); end
            checks++; if (out_sat !== 2'b00) begin errors++; $display("FAIL bp_hold_sat: cycle %0d got %b expected 00", c, out_sat); end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid: got %b expected 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b expected 1", in_ready); end
        for (int i = 0; i < 4; i++) beat(1, 1, 1, 1);
        exp_d = {12'(4), 12'(4)};
        checks++; if (out_data !== exp_d) begin errors++; $display("FAIL bp_next_data: got %h expected %h", out_data, exp_d); end
        @(posedge clk); #1;
    endtask

    task automatic test_clear;
        out_ready = 1'b0;
        beat(10, 10, 10, 10);
        beat(10, 10, 10, 10);
        clear    = 1'b1;
        in_valid = 1'b1;
        @(posedge clk); #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL clear_valid: got %b expected 0", out_valid); end
        for (int i = 0; i < 4; i++) beat(1, 1, 1, 1);
        exp_d = {12'(4), 12'(4)};
        checks++; if (out_data !== exp_d) begin errors++; $display("FAIL clear_data: got %h expected %h", out_data, exp_d); end
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL clear_drain_valid: got %b expected 1", out_valid); end
        checks++; if (out_data !== exp_d) begin errors++; $display("FAIL clear_drain_data: got %h expected %h", out_data, exp_d); end
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL clear_release: got %b expected 0", out_valid); end
    endtask

    task automatic test_reset_mid;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) beat(5, 5, 5, 5);
        #2 reset = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %b expected 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready: got %b expected 1", in_ready); end
        @(posedge clk); #1;
        reset = 1'b1;
        for (int i = 0; i < 4; i++) beat(2, 2, 2, 2);
        exp_d = {12'(16), 12'(16)};
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rst_fresh_valid: got %b expected 1", out_valid); end
        checks++; if (out_data !== exp_d) begin errors++; $display("FAIL rst_fresh_data: got %h expected %h", out_data, exp_d); end
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) beat(3, 3, 3, 3);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rst_drain_pre: got %b expected 1", out_valid); end
        #2 reset = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_drain_valid: got %b expected 0", out_valid); end
        checks++; if (out_data !== 24'h0) begin errors++; $display("FAIL rst_drain_data: got %h expected 000000", out_data); end
        @(posedge clk); #1;
        reset     = 1'b1;
        out_ready = 1'b1;
    endtask

    task automatic test_rescale;
        r_out_ready = 1'b1;
        r_in_valid  = 1'b1;
        r_in_m      = {12'(-100), 12'(-1)};
        r_in_v      = {12'(3), 12'(1)};
        @(posedge clk); #1;
        r_in_valid  = 1'b0;
`ifdef MAC_VEC_RELU_EN
        exp_d = {12'(0), 12'(0)};
`else
        exp_d = {12'(-19), 12'(-1)};
`endif
        checks++; if (r_out_valid !== 1'b1) begin errors++; $display("FAIL rs_valid: got %b expected 1", r_out_valid); end
        checks++; if (r_out_data !== exp_d) begin errors++; $display("FAIL rs_floor: got %h expected %h", r_out_data, exp_d); end
        checks++; if (r_out_sat !== 2'b00) begin errors++; $display("FAIL rs_floor_sat: got %b expected 00", r_out_sat); end
        @(posedge clk); #1;
        r_in_valid = 1'b1;
        r_in_m     = {12'(2047), 12'(100)};
        r_in_v     = {12'(2047), 12'(3)};
        @(posedge clk); #1;
        r_in_valid = 1'b0;
        exp_d = {12'(2047), 12'(18)};
        checks++; if (r_out_data !== exp_d) begin errors++; $display("FAIL rs_pos: got %h expected %h", r_out_data, exp_d); end
        checks++; if (r_out_sat !== 2'b10) begin errors++; $display("FAIL rs_pos_sat: got %b expected 10", r_out_sat); end
        @(posedge clk); #1;
    endtask

    initial begin
        reset       = 1'b0;
        clear       = 1'b0;
        in_valid    = 1'b0;
        in_m        = '0;
        in_v        = '0;
        out_ready   = 1'b1;
        r_clear     = 1'b0;
        r_in_valid  = 1'b0;
        r_in_m      = '0;
        r_in_v      = '0;
        r_out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        test_reset;
        reset = 1'b1;
        test_basic;
        test_saturation;
        test_backpressure;
        test_clear;
        test_reset_mid;
        test_rescale;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mac_vec_datapath.md
Name: mac_vec_datapath

Overview:
- Parametrised successor of the single-lane MAC datapath.
- LANES independent signed multiply-accumulate lanes consume K input beats per vector over a valid/ready stream.
- Each lane accumulates at full precision, then rescales by FRAC and saturates to WIDTH.
- Sits between the matrix/vector operand fetch logic and the output writer; one output beat per K accepted input beats.

Parameters:
- WIDTH, 12, signed operand and result width per lane.
- LANES, 2, number of parallel lanes.
- K, 4, input beats per output vector (K >= 1).
- FRAC, 0, arithmetic right shift applied to the accumulator before saturation (0 <= FRAC < WIDTH).

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-low reset.
- clear  input  1  synchronous abort: discard partial accumulation, zero beat counter.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  operand beat accepted when in_valid && in_ready.
- in_m  input  LANES*WIDTH  signed matrix operands; lane i at [i*WIDTH +: WIDTH].
- in_v  input  LANES*WIDTH  signed vector operands; same packing.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts when out_valid && out_ready.
- out_data  output  LANES*WIDTH  saturated signed results; same packing.
- out_sat  output  LANES  per-lane saturation flag, latched with out_data.

Behaviour:
- Internal widths:
  - Product is 2*WIDTH signed.
  - Accumulator ACC_W = 2*WIDTH + $clog2(K)+1 signed; it cannot overflow, so no intermediate saturation.
- Reset (reset low, asynchronous):
  - state=ACCUM, beat count=0, accumulators=0.
  - out_valid=0, out_data=0, out_sat=0.
  - Reset mid-vector discards all partial data.
- States:
  - ACCUM: in_ready=1.
    - Each handshake: acc[i] += in_m[i]*in_v[i] (all lanes), count++.
    - On the handshake where count==K-1, the final sum (acc + current product) is rescaled, saturated and registered into out_data/out_sat.
    - Same edge: out_valid=1, accumulators=0, count=0, state->DRAIN.
    - K=1: every beat is final.
  - DRAIN: in_ready=0.
    - out_data/out_sat/out_valid hold stable while out_ready=0.
    - On out_valid && out_ready: out_valid=0, state->ACCUM next cycle. Throughput is one vector per K+1 cycles minimum.
- Latency: out_valid rises on the clock edge that accepts the K-th beat; it is visible the following cycle.
- Rescale:
  - r = acc >>> FRAC (arithmetic, floor toward -inf).
  - r > 2^(WIDTH-1)-1 -> 2^(WIDTH-1)-1, out_sat=1.
  - r < -2^(WIDTH-1) -> -2^(WIDTH-1), out_sat=1.
  - Otherwise r, out_sat=0.
- clear:
  - In ACCUM: zeroes accumulators and count; any beat presented that cycle is dropped (in_ready still 1, no accumulation).
  - In DRAIN: ignored; the pending output is never corrupted.
  - clear has priority over accumulation.
- in_m/in_v are sampled only on handshake; X on them without in_valid has no effect.

Optional Feature:
- Macro MAC_VEC_RELU_EN.
- Defined: after saturation, any negative lane result is forced to 0; out_sat is set only for high-side saturation.
- Undefined: signed results pass through unchanged; out_sat flags both sides.

Test Plan:
- Basic MAC (WIDTH=12, LANES=2, K=4, FRAC=0):
  - Stimulus: lane0 m={1,2,3,4}, v={5,6,7,8}; lane1 m={-1,-2,-3,-4}, same v, 4 back-to-back beats.
  - Expected: out_data lane0=70, lane1=-70, out_sat=0; in_ready low exactly one DRAIN cycle with out_ready=1.
- Saturation:
  - Stimulus: 4 beats of lane0 m=2047,v=2047 and lane1 m=2047,v=-2048.
  - Expected: lane0=2047, lane1=-2048, out_sat=2'b11. With MAC_VEC_RELU_EN: lane1=0, out_sat=2'b01.
- Backpressure:
  - Stimulus: hold out_ready=0 for 5 cycles after out_valid.
  - Expected: out_data/out_sat stable, in_ready=0 throughout, in_valid beats not consumed; out_ready=1 -> one output transfer, then in_ready=1.
- Clear:
  - Stimulus: 2 beats of m=v=10, then clear for 1 cycle, then 4 beats of m=v=1.
  - Expected: result 4 (not 204); clear asserted during DRAIN leaves the pending result intact.
- Reset mid-vector and rescale:
  - Stimulus: reset low after 3 beats, then a fresh vector.
  - Expected: out_valid=0 immediately, clean result for the fresh vector.
  - Stimulus: FRAC=4, K=1, m=-1, v=1.
  - Expected: out_data=-1 (floor); m=100, v=3 -> 18.
